// File: rtl/cheb_term_gen.sv
// Chebyshev term source: streams T_0(x)..T_DEGREE(x) via T_{k+1} = 2x*T_k - T_{k-1}.
// Define CHEB_SAT_EN to saturate terms and raise the sticky ovf flag; otherwise terms wrap.
module cheb_term_gen #(
  parameter  int WL     = 16,
  parameter  int FRAC   = 14,
  parameter  int DEGREE = 7,
  localparam int IDX_W  = (DEGREE > 0) ? $clog2(DEGREE + 1) : 1
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic signed [WL-1:0] x_in,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [WL-1:0] out_data,
  output logic [IDX_W-1:0]     out_index,
  output logic                 out_last,
  output logic                 ovf
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic signed [WL-1:0]   ONE    = WL'(1) << FRAC;
  localparam logic signed [2*WL-1:0] RND_K  = (2*WL)'(1) << (FRAC - 2);
  localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(DEGREE);

  state_t state_q, state_d;

  logic signed [WL-1:0] x_q, x_d;
  logic signed [WL-1:0] data_q, data_d;   // presented term T_k
  logic signed [WL-1:0] prev_q, prev_d;   // T_{k-1}
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 last_q, last_d;

  logic                   accept;
  logic signed [2*WL-1:0] prod;
  logic signed [2*WL-1:0] sum;
  logic signed [WL-1:0]   t_word;
  logic                   clip;

  assign accept = valid_q & out_ready;

  // Recurrence datapath for the term following the presented one.
  assign prod = (2*WL)'(x_q) * (2*WL)'(data_q);
  assign sum  = prod + RND_K;

`ifdef CHEB_SAT_EN
  // Three guard bits: r can reach +2^(WL+1) when x = T = -2^(WL-1),
  // so the subtraction needs the extra bit to pick the right saturation side.
  localparam int TW = WL + 3;
  localparam logic signed [TW-1:0] SAT_MAX = {{(TW-WL+1){1'b0}}, {(WL-1){1'b1}}};
  localparam logic signed [TW-1:0] SAT_MIN = {{(TW-WL+1){1'b1}}, {(WL-1){1'b0}}};

  logic signed [TW-1:0] t_ext;
  logic                 ovf_q, ovf_d;

  always_comb begin
    t_ext  = TW'(sum >>> (FRAC - 1)) - TW'(prev_q);
    t_word = t_ext[WL-1:0];
    clip   = 1'b0;
    if (t_ext > SAT_MAX) begin
      t_word = {1'b0, {(WL-1){1'b1}}};
      clip   = 1'b1;
    end else if (t_ext < SAT_MIN) begin
      t_word = {1'b1, {(WL-1){1'b0}}};
      clip   = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE && start) begin
      ovf_d = 1'b0;
    end else if (state_q == EMIT && accept && !last_q && idx_q != '0 && clip) begin
      ovf_d = 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign t_word = WL'(sum >>> (FRAC - 1)) - prev_q;
  assign clip   = 1'b0;
  assign ovf    = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = EMIT;
      EMIT: if (accept && last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    x_d     = x_q;
    data_d  = data_q;
    prev_d  = prev_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = x_in;
          data_d  = ONE;
          prev_d  = '0;
          idx_d   = '0;
          last_d  = (DEGREE == 0);
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      EMIT: begin
        if (accept) begin
          if (last_q) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            last_d = ((idx_q + IDX_W'(1)) == IDX_LAST);
            prev_d = data_q;
            data_d = (idx_q == '0) ? x_q : t_word;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x_q     <= '0;
      data_q  <= '0;
      prev_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      data_q  <= data_d;
      prev_q  <= prev_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_index = idx_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_cheb_term_gen.sv
// Directed bench for cheb_term_gen (DEGREE=7 instance plus a DEGREE=0 instance).
module tb_cheb_term_gen;

  logic               clock = 1'b0;
  logic               resetn = 1'b1;
  logic               start, out_ready;
  logic signed [15:0] x_in;
  logic               busy, out_valid, out_last, ovf;
  logic signed [15:0] out_data;
  logic [2:0]         out_index;

  logic               start0, out_ready0;
  logic signed [15:0] x_in0;
  logic               busy0, out_valid0, out_last0, ovf0;
  logic signed [15:0] out_data0;
  logic [0:0]         out_index0;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  cheb_term_gen #(.WL(16), .FRAC(14), .DEGREE(7)) u_dut (
    .clock(clock), .resetn(resetn), .start(start), .x_in(x_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last), .ovf(ovf)
  );

  cheb_term_gen #(.WL(16), .FRAC(14), .DEGREE(0)) u_dut0 (
    .clock(clock), .resetn(resetn), .start(start0), .x_in(x_in0),
    .busy(busy0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_data(out_data0), .out_index(out_index0), .out_last(out_last0), .ovf(ovf0)
  );

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Pulse start on a falling edge; returns at the next falling edge with T_0 presented.
  task automatic start_run(input logic signed [15:0] x);
    @(negedge clock);
    start = 1'b1;
    x_in  = x;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic check_term(input string tag, input int k, input int expv);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_busy"},  busy, 1);
    chk({tag, "_data"},  out_data, expv);
    chk({tag, "_index"}, out_index, k);
    chk({tag, "_last"},  out_last, (k == 7) ? 1 : 0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (out_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_drain_valid"}, out_valid, 0);
    chk({tag, "_drain_busy"},  busy, 0);
  endtask

  int half_seq [8] = '{16384, 8192, -8192, -16384, -8192, 8192, 16384, 8192};

  initial begin
    start = 1'b0; out_ready = 1'b0; x_in = '0;
    start0 = 1'b0; out_ready0 = 1'b1; x_in0 = '0;
    #2 resetn = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_busy",  busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data, 0);
    chk("rst_index", out_index, 0);
    chk("rst_last",  out_last, 0);
    chk("rst_ovf",   ovf, 0);
    resetn = 1'b1;

    // x = 0.5, full throughput
    out_ready = 1'b1;
    start_run(16'sd8192);
    for (int k = 0; k < 8; k++) begin
      check_term("half", k, half_seq[k]);
      @(negedge clock);
    end
    chk("half_end_valid", out_valid, 0);
    chk("half_end_busy",  busy, 0);

    // x = 1.0: every term is 1.0
    start_run(16'sd16384);
    for (int k = 0; k < 8; k++) begin
      check_term("one", k, 16384);
      @(negedge clock);
    end
    chk("one_ovf", ovf, 0);
    chk("one_end_valid", out_valid, 0);

    // Backpressure while T_2 is presented
    start_run(16'sd8192);
    for (int k = 0; k < 2; k++) begin
      check_term("bp", k, half_seq[k]);
      @(negedge clock);
    end
    check_term("bp", 2, half_seq[2]);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check_term("bp_hold", 2, -8192);
    end
    out_ready = 1'b1;
    @(negedge clock);
    for (int k = 3; k < 8; k++) begin
      check_term("bp", k, half_seq[k]);
      @(negedge clock);
    end
    chk("bp_end_valid", out_valid, 0);

    // x = -2.0: T_2 overflows
    start_run(-16'sd32768);
    check_term("neg2", 0, 16384);
    @(negedge clock);
    check_term("neg2", 1, -32768);
    @(negedge clock);
`ifdef CHEB_SAT_EN
    check_term("neg2", 2, 32767);
    chk("neg2_ovf", ovf, 1);
`else
    check_term("neg2", 2, -16384);
    chk("neg2_ovf", ovf, 0);
`endif
    drain("neg2");

    // Start while busy is ignored; async reset mid-run
    start_run(16'sd8192);
    for (int k = 0; k < 4; k++) begin
      check_term("ign", k, half_seq[k]);
      @(negedge clock);
    end
    chk("ign_ovf_cleared", ovf, 0);
    check_term("ign", 4, half_seq[4]);
    start = 1'b1;
    x_in  = 16'sd16384;
    @(negedge clock);
    start = 1'b0;
    check_term("ign", 5, half_seq[5]);
    resetn = 1'b0;
    #1;
    chk("mrst_busy",  busy, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_data",  out_data, 0);
    chk("mrst_index", out_index, 0);
    chk("mrst_last",  out_last, 0);
    chk("mrst_ovf",   ovf, 0);
    @(negedge clock);
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) @(negedge clock);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_busy",  busy, 0);

    // DEGREE = 0 instance: one term with out_last
    @(negedge clock);
    start0 = 1'b1;
    x_in0  = 16'sd8192;
    @(negedge clock);
    start0 = 1'b0;
    chk("d0_valid", out_valid0, 1);
    chk("d0_busy",  busy0, 1);
    chk("d0_data",  out_data0, 16384);
    chk("d0_index", out_index0, 0);
    chk("d0_last",  out_last0, 1);
    @(negedge clock);
    chk("d0_end_valid", out_valid0, 0);
    chk("d0_end_busy",  busy0, 0);
    chk("d0_ovf",       ovf0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
